// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared geometry constants, scan FSM states and pixel record for the region reader
package fb_pkg;

  localparam int COORD_W  = 11;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int ADDR_W   = 19;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               color;
    logic               last;
  } pixel_t;

endpackage

// File: rtl/pixel_skid_fifo.sv
// rtl/pixel_skid_fifo.sv - two-entry pixel FIFO; push and pop in the same cycle are legal even when full
module pixel_skid_fifo
  import fb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_push,
  input  pixel_t     i_push_data,
  input  logic       i_pop,
  output pixel_t     o_head,
  output logic       o_full,
  output logic       o_empty,
  output logic [1:0] o_count
);

  pixel_t     r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_do_push;
  logic       w_do_pop;

  assign w_do_pop  = i_pop && (r_count != 2'd0);
  assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= !r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= !r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/fb_region_reader.sv
// rtl/fb_region_reader.sv - raster-order read-back of a framebuffer rectangle with a lit-pixel count
module fb_region_reader #(
  parameter int COORD_W  = fb_pkg::COORD_W,
  parameter int SCREEN_W = fb_pkg::SCREEN_W,
  parameter int SCREEN_H = fb_pkg::SCREEN_H,
  parameter int ADDR_W   = fb_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic               rd_data,
  output logic               px_valid,
  input  logic               px_ready,
  output logic [COORD_W-1:0] px_x,
  output logic [COORD_W-1:0] px_y,
  output logic               px_color,
  output logic               px_last,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  lit_count
);
  import fb_pkg::*;

  localparam logic [COORD_W-1:0] L_XLIM = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] L_YLIM = COORD_W'(SCREEN_H - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [COORD_W-1:0] r_cx0, r_cy0, r_cx1, r_cy1;
  logic [COORD_W-1:0] w_cx0, w_cy0, w_cx1, w_cy1;
  logic [COORD_W-1:0] w_xmin, w_xmax, w_ymin, w_ymax;
  logic [COORD_W-1:0] r_xmin, r_xmax, r_ymax;
  logic [COORD_W-1:0] r_x, r_y;
  logic [ADDR_W-1:0]  r_row_base;
  logic [ADDR_W-1:0]  w_row_base0;
  logic               r_if_valid;
  logic [COORD_W-1:0] r_if_x, r_if_y;
  logic               r_if_last;
  logic [ADDR_W-1:0]  r_lit;
  logic               w_at_end;
  logic               w_rd_go;
  logic               w_pop;
  logic               w_push;
  logic [2:0]         w_occ;
  pixel_t             w_push_data;
  pixel_t             w_head;
  logic               w_full;
  logic               w_empty;
  logic [1:0]         w_count;

  always_comb begin
    w_cx0  = (r_cx0 > L_XLIM) ? L_XLIM : r_cx0;
    w_cx1  = (r_cx1 > L_XLIM) ? L_XLIM : r_cx1;
    w_cy0  = (r_cy0 > L_YLIM) ? L_YLIM : r_cy0;
    w_cy1  = (r_cy1 > L_YLIM) ? L_YLIM : r_cy1;
    w_xmin = (w_cx0 < w_cx1) ? w_cx0 : w_cx1;
    w_xmax = (w_cx0 < w_cx1) ? w_cx1 : w_cx0;
    w_ymin = (w_cy0 < w_cy1) ? w_cy0 : w_cy1;
    w_ymax = (w_cy0 < w_cy1) ? w_cy1 : w_cy0;
  end

  // First row base as a constant-coefficient shift-add over the set bits of SCREEN_W.
  always_comb begin
    w_row_base0 = '0;
    for (int b = 0; b < ADDR_W; b++) begin
      if (SCREEN_W[b]) w_row_base0 = w_row_base0 + (ADDR_W'(w_ymin) << b);
    end
  end

  assign w_at_end = (r_x == r_xmax) && (r_y == r_ymax);
  assign w_pop    = !w_empty && px_ready;
  // Reads already issued plus buffered pixels, minus the one leaving this cycle.
  assign w_occ    = {1'b0, w_count} + {2'b00, r_if_valid} - {2'b00, w_pop};

  always_comb begin
    w_next_state = r_state;
    w_rd_go      = 1'b0;
    case (r_state)
      IDLE:    if (start) w_next_state = SETUP;
      SETUP:   w_next_state = SCAN;
      SCAN: begin
        w_rd_go = (w_occ < 3'd2);
        if (w_rd_go && w_at_end) w_next_state = DRAIN;
      end
      DRAIN:   if (w_pop && w_head.last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cx0   <= '0;
      r_cy0   <= '0;
      r_cx1   <= '0;
      r_cy1   <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE && start) begin
        r_cx0 <= x0;
        r_cy0 <= y0;
        r_cx1 <= x1;
        r_cy1 <= y1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_xmin     <= '0;
      r_xmax     <= '0;
      r_ymax     <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_row_base <= '0;
    end else if (r_state == SETUP) begin
      r_xmin     <= w_xmin;
      r_xmax     <= w_xmax;
      r_ymax     <= w_ymax;
      r_x        <= w_xmin;
      r_y        <= w_ymin;
      r_row_base <= w_row_base0;
    end else if (w_rd_go) begin
      if (r_x == r_xmax) begin
        r_x        <= r_xmin;
        r_y        <= r_y + COORD_W'(1);
        r_row_base <= r_row_base + ADDR_W'(SCREEN_W);
      end else begin
        r_x <= r_x + COORD_W'(1);
      end
    end
  end

  // Coordinates and last flag travel beside the read so they meet rd_data one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_if_valid <= 1'b0;
      r_if_x     <= '0;
      r_if_y     <= '0;
      r_if_last  <= 1'b0;
      r_lit      <= '0;
    end else begin
      r_if_valid <= w_rd_go;
      r_if_x     <= r_x;
      r_if_y     <= r_y;
      r_if_last  <= w_at_end;
      if (r_state == SETUP) begin
        r_lit <= '0;
      end else if (w_pop && w_head.color) begin
        r_lit <= r_lit + ADDR_W'(1);
      end
    end
  end

  assign w_push      = r_if_valid && (!w_full || w_pop);
  assign w_push_data = {r_if_x, r_if_y, rd_data, r_if_last};

  pixel_skid_fifo u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  assign rd_en     = w_rd_go;
  assign rd_addr   = r_row_base + ADDR_W'(r_x);
  assign px_valid  = !w_empty;
  assign px_x      = w_head.x;
  assign px_y      = w_head.y;
  assign px_color  = w_head.color;
  assign px_last   = w_head.last;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign lit_count = r_lit;

endmodule

// File: tb/tb_fb_region_reader.sv
// tb/tb_fb_region_reader.sv - directed self-checking bench for fb_region_reader
`timescale 1ns/1ps
module tb_fb_region_reader;

  localparam int CW = 11;
  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [CW-1:0] x0, y0, x1, y1;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_data;
  logic          px_valid;
  logic          px_ready;
  logic [CW-1:0] px_x, px_y;
  logic          px_color, px_last, busy, done;
  logic [AW-1:0] lit_count;

  int checks   = 0;
  int failures = 0;
  int mem_mode = 0;

  int sx[$], sy[$], sc[$], sl[$], sa[$];
  int done_cyc;
  bit stable_ok, bound_ok, busy_ok;
  logic [CW-1:0] nx0, ny0, nx1, ny1;

  int exp_x[6] = '{10, 11, 12, 10, 11, 12};
  int exp_y[6] = '{3, 3, 3, 4, 4, 4};
  int exp_c[6] = '{0, 1, 0, 1, 0, 0};

  always #5 clk = ~clk;

  fb_region_reader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .px_valid  (px_valid),
    .px_ready  (px_ready),
    .px_x      (px_x),
    .px_y      (px_y),
    .px_color  (px_color),
    .px_last   (px_last),
    .busy      (busy),
    .done      (done),
    .lit_count (lit_count)
  );

  // Frame memory: (5,7)=4485, (11,3)=1931, (10,4)=2570.
  function automatic logic mem_px(input int mode, input int addr);
    case (mode)
      0:       return addr == 4485;
      1:       return (addr == 1931) || (addr == 2570);
      2:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) rd_data <= rd_en ? mem_px(mem_mode, int'(rd_addr)) : 1'b0;

  function automatic logic ready_at(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    return (cyc % 3) == 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic run_scan(input int rmode, input bit keep_start, input bit chained, input int limit);
    int issued;
    int xfer;
    bit pstall;
    logic [2*CW+2:0] psnap;
    sx.delete(); sy.delete(); sc.delete(); sl.delete(); sa.delete();
    done_cyc = -1; stable_ok = 1; bound_ok = 1; busy_ok = 1;
    issued = 0; xfer = 0; pstall = 0; psnap = '0;
    if (chained) begin
      @(posedge clk); #2;
      check("idle_gap_busy", busy, 0);
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1; start = 1;
      @(posedge clk); #1;
    end
    if (keep_start) begin
      x0 = nx0; y0 = ny0; x1 = nx1; y1 = ny1;
    end else begin
      start = 0;
    end
    for (int cyc = 1; cyc <= limit; cyc++) begin
      px_ready = ready_at(rmode, cyc);
      #1;
      if (issued - xfer > 2) bound_ok = 0;
      if (busy !== 1'b1) busy_ok = 0;
      if (pstall && ({px_valid, px_x, px_y, px_color, px_last} !== psnap)) stable_ok = 0;
      if (rd_en) begin
        sa.push_back(int'(rd_addr));
        issued++;
      end
      if (px_valid && px_ready) begin
        sx.push_back(int'(px_x)); sy.push_back(int'(px_y));
        sc.push_back(int'(px_color)); sl.push_back(int'(px_last));
        xfer++;
      end
      pstall = px_valid && !px_ready;
      psnap  = {px_valid, px_x, px_y, px_color, px_last};
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_region(input string tag);
    check({tag, "_count"}, sx.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < sx.size()) begin
        check($sformatf("%s_x%0d", tag, i), sx[i], exp_x[i]);
        check($sformatf("%s_y%0d", tag, i), sy[i], exp_y[i]);
        check($sformatf("%s_c%0d", tag, i), sc[i], exp_c[i]);
        check($sformatf("%s_l%0d", tag, i), sl[i], (i == 5) ? 1 : 0);
      end
    end
    check({tag, "_lit"}, lit_count, 2);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit saw;
    reset_n = 0; start = 0; px_ready = 0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    nx0 = '0; ny0 = '0; nx1 = '0; ny1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_px_valid", px_valid, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_lit", lit_count, 0);
    check("rst_px_fields", {px_x, px_y, px_color, px_last}, 0);
    reset_n = 1;

    // Single lit pixel, degenerate rectangle
    mem_mode = 0; x0 = 5; y0 = 7; x1 = 5; y1 = 7;
    run_scan(0, 0, 0, 40);
    check("t1_done_cyc", done_cyc, 5);
    check("t1_count", sx.size(), 1);
    if (sx.size() == 1) begin
      check("t1_x", sx[0], 5);
      check("t1_y", sy[0], 7);
      check("t1_color", sc[0], 1);
      check("t1_last", sl[0], 1);
    end
    check("t1_addr", (sa.size() > 0) ? sa[0] : -1, 4485);
    check("t1_lit", lit_count, 1);
    check("t1_busy", busy_ok, 1);

    // Swapped corners, full throughput
    mem_mode = 1; x0 = 12; y0 = 4; x1 = 10; y1 = 3;
    run_scan(0, 0, 0, 40);
    check("t2_done_cyc", done_cyc, 10);
    check_region("t2");
    check("t2_addr_10_4", (sa.size() > 3) ? sa[3] : -1, 2570);
    check("t2_busy", busy_ok, 1);

    // Same region with back-pressure
    run_scan(1, 0, 0, 80);
    check("t3_done_seen", done_cyc > 0, 1);
    check_region("t3");
    check("t3_stable", stable_ok, 1);
    check("t3_inflight_bound", bound_ok, 1);

    // Clipping at the bottom-right screen corner
    mem_mode = 2; x0 = 638; y0 = 478; x1 = 700; y1 = 500;
    run_scan(0, 0, 0, 40);
    check("t4_done_cyc", done_cyc, 8);
    check("t4_count", sx.size(), 4);
    if (sx.size() == 4) begin
      check("t4_first_x", sx[0], 638);
      check("t4_first_y", sy[0], 478);
      check("t4_last_x", sx[3], 639);
      check("t4_last_y", sy[3], 479);
    end
    check("t4_last_addr", (sa.size() > 0) ? sa[sa.size()-1] : -1, 307199);
    check("t4_lit", lit_count, 4);

    // Reset mid-scan of a 20x20 region
    mem_mode = 2; x0 = 0; y0 = 0; x1 = 19; y1 = 19; px_ready = 1;
    @(posedge clk); #1; start = 1;
    @(posedge clk); #1; start = 0;
    repeat (5) @(posedge clk);
    #1;
    check("t5_pre_busy", busy, 1);
    check("t5_pre_lit", lit_count, 2);
    reset_n = 0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_rd_en", rd_en, 0);
    check("t5_rst_valid", px_valid, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_lit", lit_count, 0);
    check("t5_rst_rd_addr", rd_addr, 0);
    check("t5_rst_px_fields", {px_x, px_y, px_color, px_last}, 0);
    @(posedge clk); #1; reset_n = 1;
    saw = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done || busy) saw = 1;
    end
    check("t5_no_done", saw, 0);
    mem_mode = 0; x0 = 5; y0 = 7; x1 = 5; y1 = 7;
    run_scan(0, 0, 0, 40);
    check("t5_after_done_cyc", done_cyc, 5);
    check("t5_after_count", sx.size(), 1);
    check("t5_after_lit", lit_count, 1);

    // start held high with new corners during the scan
    mem_mode = 1; x0 = 10; y0 = 4; x1 = 11; y1 = 4;
    nx0 = 11; ny0 = 3; nx1 = 11; ny1 = 3;
    run_scan(0, 1, 0, 40);
    check("t6a_done_cyc", done_cyc, 6);
    check("t6a_count", sx.size(), 2);
    if (sx.size() == 2) begin
      check("t6a_x0", sx[0], 10);
      check("t6a_y0", sy[0], 4);
      check("t6a_x1", sx[1], 11);
    end
    check("t6a_lit", lit_count, 1);
    run_scan(0, 1, 1, 40);
    start = 0;
    check("t6b_done_cyc", done_cyc, 5);
    check("t6b_count", sx.size(), 1);
    if (sx.size() == 1) begin
      check("t6b_x", sx[0], 11);
      check("t6b_y", sy[0], 3);
    end
    check("t6b_lit", lit_count, 1);
    repeat (3) @(posedge clk);
    #1;
    check("t6_final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
